// File: rtl/ms_qspi_xip_ahbl_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ms_qspi_xip_pkg
// Purpose  : Shared AHB-Lite transfer encodings and arbitration-mode
//            constants for the QSPI XIP two-master read arbiter.
// Contents : htrans_t, HTRANS_IDLE/HTRANS_NONSEQ, PRIO_RR/PRIO_FIXED
// Revision : 1.0 - initial release
// ============================================================================
package ms_qspi_xip_pkg;

  typedef logic [1:0] htrans_t;

  localparam htrans_t HTRANS_IDLE   = 2'b00;
  localparam htrans_t HTRANS_NONSEQ = 2'b10;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage : ms_qspi_xip_pkg
`default_nettype wire

// File: rtl/ms_qspi_xip_ahbl_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : ms_qspi_xip_ahbl_arbiter_if
// Purpose   : One AHB-Lite link (address/control out, ready/data back).
// Modports  : master - drives HSEL/HADDR/HTRANS/HWRITE/HREADY,
//                      receives HREADYOUT/HRDATA
//             slave  - the mirror image
// Revision  : 1.0 - initial release
// ============================================================================
interface ms_qspi_xip_ahbl_arbiter_if;
  import ms_qspi_xip_pkg::*;

  logic        HSEL;
  logic [31:0] HADDR;
  htrans_t     HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HREADY,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HREADY,
    output HREADYOUT, HRDATA
  );

endinterface : ms_qspi_xip_ahbl_arbiter_if
`default_nettype wire

// File: rtl/ms_qspi_xip_ahbl_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module   : ms_ahbl_rr_grant
// Purpose  : Two-way grant with last-grant pointer and grant lock.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            i_req[1:0]     - pending requests (bit m = master m)
//            i_hold         - address phase stalled; freeze current grant
//            i_accept       - grant accepted by slave; update last pointer
//            o_gnt          - granted master index
// Revision : 1.0 - initial release
// ============================================================================
module ms_ahbl_rr_grant
  import ms_qspi_xip_pkg::*;
#(
  parameter int PRIORITY_MODE = PRIO_RR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_hold,
  input  logic       i_accept,
  output logic       o_gnt
);

  logic r_last;
  logic r_lock;
  logic r_gnt_q;
  logic w_arb;

  always_comb begin
    w_arb = 1'b0;
    case (i_req)
      2'b01:   w_arb = 1'b0;
      2'b10:   w_arb = 1'b1;
      // Tie: fixed mode favours M0, round-robin favours whoever was not last.
      2'b11:   w_arb = (PRIORITY_MODE == PRIO_FIXED) ? 1'b0 : ~r_last;
      default: w_arb = 1'b0;
    endcase
  end

  // A stalled address phase must keep presenting the same master.
  assign o_gnt = r_lock ? r_gnt_q : w_arb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last  <= 1'b1;  // M0 wins the first round-robin tie
      r_lock  <= 1'b0;
      r_gnt_q <= 1'b0;
    end else begin
      r_lock  <= i_hold;
      r_gnt_q <= o_gnt;
      if (i_accept) begin
        r_last <= o_gnt;
      end
    end
  end

endmodule : ms_ahbl_rr_grant
`default_nettype wire

// File: rtl/ms_qspi_xip_ahbl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ms_qspi_xip_ahbl_arbiter
// Purpose  : Shares the XIP cache AHB-Lite slave port between an
//            instruction master (M0) and a data master (M1). Read address
//            phases are registered per master, arbitrated, and completions
//            are routed back to the owning master. Writes are absorbed.
// Ports    : HCLK, HRESET - clock, synchronous active-high reset
//            M0, M1       - master-side links (slave modport)
//            S            - link to the XIP cache (master modport)
// Revision : 1.0 - initial release
// ============================================================================
module ms_qspi_xip_ahbl_arbiter
  import ms_qspi_xip_pkg::*;
#(
  parameter int PRIORITY_MODE = PRIO_RR
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  ms_qspi_xip_ahbl_arbiter_if.slave   M0,
  ms_qspi_xip_ahbl_arbiter_if.slave   M1,
  ms_qspi_xip_ahbl_arbiter_if.master  S
);

  logic [1:0]  r_pend;
  logic [31:0] r_paddr [2];
  logic        r_busy;
  logic        r_owner;

  logic [1:0]  w_cap;
  logic [31:0] w_haddr [2];
  logic        w_aphase;
  logic        w_accept;
  logic        w_hold;
  logic        w_gnt;
  logic        w_unused;

  // Only reads are captured; writes fall through with HREADYOUT high.
  assign w_cap[0]   = M0.HSEL & M0.HTRANS[1] & M0.HREADY & ~M0.HWRITE;
  assign w_cap[1]   = M1.HSEL & M1.HTRANS[1] & M1.HREADY & ~M1.HWRITE;
  assign w_haddr[0] = M0.HADDR;
  assign w_haddr[1] = M1.HADDR;

  assign w_aphase = |r_pend;
  assign w_accept = w_aphase &  S.HREADYOUT;
  assign w_hold   = w_aphase & ~S.HREADYOUT;

  ms_ahbl_rr_grant #(
    .PRIORITY_MODE (PRIORITY_MODE)
  ) u_grant (
    .clk      (HCLK),
    .rst      (HRESET),
    .i_req    (r_pend),
    .i_hold   (w_hold),
    .i_accept (w_accept),
    .o_gnt    (w_gnt)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_pend     <= 2'b00;
      r_paddr[0] <= '0;
      r_paddr[1] <= '0;
      r_busy     <= 1'b0;
      r_owner    <= 1'b0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (w_accept && (w_gnt == 1'(m))) begin
          r_pend[m] <= 1'b0;
        end
        if (w_cap[m]) begin
          r_pend[m]  <= 1'b1;
          r_paddr[m] <= w_haddr[m];
        end
      end
      // A new acceptance on the completion edge keeps busy asserted.
      if (w_accept) begin
        r_busy  <= 1'b1;
        r_owner <= w_gnt;
      end else if (r_busy && S.HREADYOUT) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Slave side is driven purely from registers.
  assign S.HSEL   = w_aphase;
  assign S.HTRANS = w_aphase ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign S.HADDR  = w_aphase ? r_paddr[w_gnt] : 32'h0;
  assign S.HWRITE = 1'b0;
  assign S.HREADY = S.HREADYOUT;

  assign M0.HREADYOUT = ~(r_pend[0] | (r_busy & ~r_owner & ~S.HREADYOUT));
  assign M1.HREADYOUT = ~(r_pend[1] | (r_busy &  r_owner & ~S.HREADYOUT));
  assign M0.HRDATA    = S.HRDATA;
  assign M1.HRDATA    = S.HRDATA;

  assign w_unused = &{1'b0, M0.HTRANS[0], M1.HTRANS[0]};

endmodule : ms_qspi_xip_ahbl_arbiter
`default_nettype wire

// File: tb/tb_ms_qspi_xip_ahbl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ms_qspi_xip_ahbl_arbiter
// Purpose  : Scoreboard bench for the XIP read arbiter. Instance 0 runs in
//            round-robin mode, instance 1 in fixed-priority mode. Each has
//            a small cache model (16-byte lines, 3 wait states on miss)
//            over a flash image where byte[a] = a & 0xFF.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ms_qspi_xip_ahbl_arbiter;

  typedef struct {
    int          m;
    logic [31:0] d;
    int          lmin;
    int          lmax;
  } exp_t;

  logic clk;
  logic rst;

  // Master stimulus per [instance][master]
  logic        m_hsel   [2][2];
  logic [31:0] m_haddr  [2][2];
  logic [1:0]  m_htrans [2][2];
  logic        m_hwrite [2][2];

  // Observed DUT signals per instance
  logic [1:0]  hro      [2];
  logic [31:0] rdat     [2][2];
  logic        s_hsel   [2];
  logic [31:0] s_haddr  [2];
  logic [1:0]  s_htrans [2];
  logic        s_hwrite [2];
  logic        s_hready [2];
  logic        s_rdy    [2];
  logic [31:0] s_rdata  [2];

  // Cache model state per instance
  logic        sv_act   [2];
  logic [31:0] sv_addr  [2];
  int          sv_wait  [2];
  logic [15:0] sv_valid [2];

  exp_t q0[$];
  exp_t q1[$];
  logic dph  [2][2];
  int   lowc [2][2];
  logic        prev_hold [2];
  logic [31:0] prev_addr [2];

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [31:0] flash_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ms_qspi_xip_ahbl_arbiter_if m0_if ();
    ms_qspi_xip_ahbl_arbiter_if m1_if ();
    ms_qspi_xip_ahbl_arbiter_if s_if ();

    assign m0_if.HSEL   = m_hsel[g][0];
    assign m0_if.HADDR  = m_haddr[g][0];
    assign m0_if.HTRANS = m_htrans[g][0];
    assign m0_if.HWRITE = m_hwrite[g][0];
    assign m0_if.HREADY = m0_if.HREADYOUT;
    assign m1_if.HSEL   = m_hsel[g][1];
    assign m1_if.HADDR  = m_haddr[g][1];
    assign m1_if.HTRANS = m_htrans[g][1];
    assign m1_if.HWRITE = m_hwrite[g][1];
    assign m1_if.HREADY = m1_if.HREADYOUT;

    assign s_if.HREADYOUT = !sv_act[g] || (sv_wait[g] == 0);
    assign s_if.HRDATA    = flash_word(sv_addr[g]);

    assign hro[g]      = {m1_if.HREADYOUT, m0_if.HREADYOUT};
    assign rdat[g][0]  = m0_if.HRDATA;
    assign rdat[g][1]  = m1_if.HRDATA;
    assign s_hsel[g]   = s_if.HSEL;
    assign s_haddr[g]  = s_if.HADDR;
    assign s_htrans[g] = s_if.HTRANS;
    assign s_hwrite[g] = s_if.HWRITE;
    assign s_hready[g] = s_if.HREADY;
    assign s_rdy[g]    = s_if.HREADYOUT;
    assign s_rdata[g]  = s_if.HRDATA;

    ms_qspi_xip_ahbl_arbiter #(
      .PRIORITY_MODE (g)
    ) u_dut (
      .HCLK   (clk),
      .HRESET (rst),
      .M0     (m0_if),
      .M1     (m1_if),
      .S      (s_if)
    );
  end

  // Cache model: accepts on HREADYOUT, 0 wait states on hit, 3 on miss.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        sv_act[i]   <= 1'b0;
        sv_addr[i]  <= 32'h0;
        sv_wait[i]  <= 0;
        sv_valid[i] <= 16'h0;
      end else if (s_rdy[i]) begin
        sv_act[i] <= 1'b0;
        if (s_hsel[i] && s_htrans[i][1]) begin
          sv_act[i]  <= 1'b1;
          sv_addr[i] <= s_haddr[i];
          sv_wait[i] <= sv_valid[i][s_haddr[i][7:4]] ? 0 : 3;
          sv_valid[i][s_haddr[i][7:4]] <= 1'b1;
        end
      end else begin
        sv_wait[i] <= sv_wait[i] - 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic complete(input int i, input int m, input logic [31:0] data, input int low);
    exp_t e;
    int   sz;
    sz = (i == 0) ? q0.size() : q1.size();
    n_checks++;
    if (sz == 0) begin
      n_err++;
      $display("FAIL i%0d m%0d unexpected completion: got data %h expected none", i, m, data);
      return;
    end
    if (i == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    if (e.m != m) begin
      n_err++;
      $display("FAIL i%0d order: got master %0d expected master %0d", i, m, e.m);
    end
    check($sformatf("i%0d m%0d rdata", i, m), data, e.d);
    n_checks++;
    if (low < e.lmin || low > e.lmax) begin
      n_err++;
      $display("FAIL i%0d m%0d hreadyout-low cycles: got %0d expected %0d..%0d",
               i, m, low, e.lmin, e.lmax);
    end
  endtask

  // Monitor: pops the scoreboard at each master completion.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
        prev_hold[i] = 1'b0;
        for (int m = 0; m < 2; m++) dph[i][m] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (prev_hold[i]) begin
          check($sformatf("i%0d S_HSEL held", i), {31'h0, s_hsel[i]}, 32'h1);
          check($sformatf("i%0d S_HADDR stable", i), s_haddr[i], prev_addr[i]);
        end
        prev_hold[i] = s_hsel[i] && !s_rdy[i];
        prev_addr[i] = s_haddr[i];
        for (int m = 0; m < 2; m++) begin
          if (dph[i][m]) begin
            if (hro[i][m]) begin
              complete(i, m, rdat[i][m], lowc[i][m]);
              dph[i][m] = 1'b0;
            end else begin
              lowc[i][m]++;
              if (lowc[i][m] > 300) begin
                n_checks++;
                n_err++;
                $display("FAIL i%0d m%0d timeout: got no completion expected one within 300 cycles", i, m);
                dph[i][m] = 1'b0;
              end
            end
          end
          if (m_hsel[i][m] && m_htrans[i][m][1] && !m_hwrite[i][m] && hro[i][m]) begin
            dph[i][m]  = 1'b1;
            lowc[i][m] = 0;
          end
        end
      end
    end
  end

  task automatic drive(input int i, input int m, input logic sel, input logic [1:0] tr,
                       input logic wr, input logic [31:0] a);
    m_hsel[i][m]   = sel;
    m_htrans[i][m] = tr;
    m_hwrite[i][m] = wr;
    m_haddr[i][m]  = a;
  endtask

  // Issue one read and wait until it is captured; returns at capture edge + 1.
  task automatic rd(input int i, input int m, input logic [31:0] a, input logic [31:0] d,
                    input int lmin, input int lmax);
    int n;
    n = 0;
    drive(i, m, 1'b1, 2'b10, 1'b0, a);
    do begin
      @(negedge clk);
      n++;
    end while (!hro[i][m] && n < 200);
    if (!hro[i][m]) begin
      n_checks++;
      n_err++;
      $display("FAIL i%0d m%0d issue timeout: got HREADYOUT 0 expected 1", i, m);
      drive(i, m, 1'b0, 2'b00, 1'b0, 32'h0);
      return;
    end
    @(posedge clk);
    push(i, '{m, d, lmin, lmax});
    #1;
    drive(i, m, 1'b0, 2'b00, 1'b0, 32'h0);
  endtask

  // Simultaneous M0/M1 reads; expectations pushed in the expected service order.
  task automatic rd2(input int i, input logic [31:0] a0, input logic [31:0] d0,
                     input logic [31:0] a1, input logic [31:0] d1, input bit m0_first);
    int n;
    n = 0;
    drive(i, 0, 1'b1, 2'b10, 1'b0, a0);
    drive(i, 1, 1'b1, 2'b10, 1'b0, a1);
    do begin
      @(negedge clk);
      n++;
    end while (hro[i] != 2'b11 && n < 200);
    if (hro[i] != 2'b11) begin
      n_checks++;
      n_err++;
      $display("FAIL i%0d tie issue timeout: got HREADYOUT %b expected 11", i, hro[i]);
    end else begin
      @(posedge clk);
      if (m0_first) begin
        push(i, '{0, d0, 1, 300});
        push(i, '{1, d1, 1, 300});
      end else begin
        push(i, '{1, d1, 1, 300});
        push(i, '{0, d0, 1, 300});
      end
      #1;
    end
    drive(i, 0, 1'b0, 2'b00, 1'b0, 32'h0);
    drive(i, 1, 1'b0, 2'b00, 1'b0, 32'h0);
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (n < 300 && (((i == 0) ? q0.size() : q1.size()) != 0 || dph[i][0] || dph[i][1]));
    if (n >= 300) begin
      n_checks++;
      n_err++;
      $display("FAIL i%0d idle timeout: got outstanding reads expected none", i);
    end
  endtask

  task automatic rst_chk(input int i);
    check($sformatf("i%0d rst HREADYOUT", i), {30'h0, hro[i]}, 32'h3);
    check($sformatf("i%0d rst S_HSEL", i), {31'h0, s_hsel[i]}, 32'h0);
    check($sformatf("i%0d rst S_HTRANS", i), {30'h0, s_htrans[i]}, 32'h0);
    check($sformatf("i%0d rst S_HADDR", i), s_haddr[i], 32'h0);
    check($sformatf("i%0d rst S_HWRITE", i), {31'h0, s_hwrite[i]}, 32'h0);
    check($sformatf("i%0d rst S_HREADY", i), {31'h0, s_hready[i]}, {31'h0, s_rdy[i]});
    check($sformatf("i%0d rst M0_HRDATA", i), rdat[i][0], s_rdata[i]);
    check($sformatf("i%0d rst M1_HRDATA", i), rdat[i][1], s_rdata[i]);
  endtask

  // Two-cycle reset; outputs checked after the first reset edge.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_chk(0);
    rst_chk(1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++)
      for (int m = 0; m < 2; m++)
        drive(i, m, 1'b0, 2'b00, 1'b0, 32'h0);
    do_reset();

    // Miss then pipelined hit on M0
    rd(0, 0, 32'h0, 32'h03020100, 2, 300);
    rd(0, 0, 32'h4, 32'h07060504, 1, 1);
    wait_idle(0);

    // Round-robin ties from reset: M0 first
    do_reset();
    rd2(0, 32'h08, 32'h0b0a0908, 32'h20, 32'h23222120, 1'b1);
    wait_idle(0);
    // M0 alone becomes last, so the next two ties go to M1 first
    rd(0, 0, 32'h0, 32'h03020100, 1, 300);
    wait_idle(0);
    rd2(0, 32'h08, 32'h0b0a0908, 32'h20, 32'h23222120, 1'b0);
    wait_idle(0);
    rd2(0, 32'h08, 32'h0b0a0908, 32'h20, 32'h23222120, 1'b0);
    wait_idle(0);

    // M1 write is absorbed, then a read of the same address
    @(posedge clk);
    #1;
    drive(0, 1, 1'b1, 2'b10, 1'b1, 32'h10);
    @(negedge clk);
    check("write M1_HREADYOUT", {31'h0, hro[0][1]}, 32'h1);
    check("write S_HSEL", {31'h0, s_hsel[0]}, 32'h0);
    @(posedge clk);
    #1;
    drive(0, 1, 1'b0, 2'b00, 1'b0, 32'h0);
    @(negedge clk);
    check("post-write M1_HREADYOUT", {31'h0, hro[0][1]}, 32'h1);
    check("post-write S_HSEL", {31'h0, s_hsel[0]}, 32'h0);
    @(posedge clk);
    #1;
    rd(0, 1, 32'h10, 32'h13121110, 1, 300);
    wait_idle(0);

    // Reset in the middle of an M0 miss data phase
    rd(0, 0, 32'h40, 32'h43424140, 0, 300);
    @(posedge clk);
    @(posedge clk);
    #1;
    do_reset();
    rd(0, 0, 32'hC, 32'h0f0e0d0c, 2, 300);
    wait_idle(0);

    // Back-to-back M0 reads
    rd(0, 0, 32'h0, 32'h03020100, 1, 1);
    rd(0, 0, 32'h4, 32'h07060504, 1, 1);
    rd(0, 0, 32'h8, 32'h0b0a0908, 1, 1);
    rd(0, 0, 32'hC, 32'h0f0e0d0c, 1, 1);
    wait_idle(0);

    // Fixed priority: M0 first on every tie
    rd2(1, 32'h08, 32'h0b0a0908, 32'h20, 32'h23222120, 1'b1);
    wait_idle(1);
    rd2(1, 32'h00, 32'h03020100, 32'h24, 32'h27262524, 1'b1);
    wait_idle(1);
    rd2(1, 32'h10, 32'h13121110, 32'h30, 32'h33323130, 1'b1);
    wait_idle(1);
    rd2(1, 32'h04, 32'h07060504, 32'h14, 32'h17161514, 1'b1);
    wait_idle(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_ms_qspi_xip_ahbl_arbiter
`default_nettype wire
